// File: rtl/fight_pkg.sv
`default_nettype none
// ============================================================================
// fight_pkg
// Shared types and constants for the fighting game and its match referee.
// Revision: 1.0
// ============================================================================
package fight_pkg;

  localparam int HEALTH_W = 2;
  localparam int ACTION_W = 3;

  // Referee state encodings, also exported on refState for debug.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'b000,
    ST_ROUND_RESET = 3'b001,
    ST_FIGHT       = 3'b010,
    ST_ROUND_END   = 3'b011,
    ST_MATCH_OVER  = 3'b100
  } ref_state_t;

  // Action codes understood by fightingGame.
  localparam logic [ACTION_W-1:0] ACT_NONE    = 3'd0;
  localparam logic [ACTION_W-1:0] ACT_PUNCH   = 3'd1;
  localparam logic [ACTION_W-1:0] ACT_KICK    = 3'd2;
  localparam logic [ACTION_W-1:0] ACT_BLOCK   = 3'd3;
  localparam logic [ACTION_W-1:0] ACT_SPECIAL = 3'd4;

endpackage
`default_nettype wire

// File: rtl/round_timer.sv
`default_nettype none
// ============================================================================
// round_timer
// Clearable up-counter with a terminal-count flag. Counting stops at the
// terminal value; the referee always leaves FIGHT there, so it never wraps.
// Revision: 1.0
// ============================================================================
module round_timer #(
  parameter int ROUND_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int TW = $clog2(ROUND_TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(ROUND_TIMEOUT - 1);

  logic [TW-1:0] count;

  assign tc = (count == LAST);

  // Count FIGHT cycles; clear ahead of each round, hold at terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && !tc)
      count <= count + 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/match_referee.sv
`default_nettype none
// ============================================================================
// match_referee
// Runs a best-of-N match on top of fightingGame: resets the game between
// rounds, gates its action strobe, and keeps scores and the match result.
// Revision: 1.0
// ============================================================================
module match_referee
  import fight_pkg::*;
#(
  parameter int WINS_TO_MATCH = 2,
  parameter int HOLD_CYCLES   = 4,
  parameter int ROUND_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                resetGame,
  input  logic                startMatch,
  input  logic                firstWin,
  input  logic                secondWin,
  input  logic [HEALTH_W-1:0] health1,
  input  logic [HEALTH_W-1:0] health2,
  input  logic                actionEnableIn,
  output logic                actionEnableOut,
  output logic                gameResetN,
  output logic                fightEn,
  output logic [1:0]          score1,
  output logic [1:0]          score2,
  output logic [2:0]          roundNum,
  output logic                matchOver,
  output logic                p1Match,
  output logic                p2Match,
  output logic [2:0]          refState
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [1:0]        WIN_CNT   = 2'(WINS_TO_MATCH);

  ref_state_t       state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout;

  round_timer #(.ROUND_TIMEOUT(ROUND_TIMEOUT)) u_timer (
    .clk   (clk),
    .rst_n (resetGame),
    .clr   (state == ST_ROUND_RESET),
    .en    (state == ST_FIGHT),
    .tc    (timeout)
  );

  // The only combinational output: player actions pass only while fighting.
  assign actionEnableOut = actionEnableIn & fightEn;
  assign refState        = state;

  // Referee FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (!resetGame) begin
      state      <= ST_IDLE;
      gameResetN <= 1'b0;
      fightEn    <= 1'b0;
      score1     <= 2'd0;
      score2     <= 2'd0;
      roundNum   <= 3'd0;
      matchOver  <= 1'b0;
      p1Match    <= 1'b0;
      p2Match    <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          gameResetN <= 1'b0;
          fightEn    <= 1'b0;
          if (startMatch) begin
            state    <= ST_ROUND_RESET;
            score1   <= 2'd0;
            score2   <= 2'd0;
            roundNum <= 3'd0;
          end
        end

        ST_ROUND_RESET: begin
          state      <= ST_FIGHT;
          gameResetN <= 1'b1;
          fightEn    <= 1'b1;
          if (roundNum != 3'd7)
            roundNum <= roundNum + 3'd1;
        end

        ST_FIGHT: begin
          // A simultaneous win is a draw; the timeout falls back to health.
          if (firstWin || secondWin || timeout) begin
            state    <= ST_ROUND_END;
            fightEn  <= 1'b0;
            hold_cnt <= '0;
          end
          if (firstWin && secondWin) begin
            // draw: scores unchanged
          end else if (firstWin) begin
            if (score1 != WIN_CNT) score1 <= score1 + 2'd1;
          end else if (secondWin) begin
            if (score2 != WIN_CNT) score2 <= score2 + 2'd1;
          end else if (timeout) begin
            if (health1 > health2 && score1 != WIN_CNT)
              score1 <= score1 + 2'd1;
            else if (health2 > health1 && score2 != WIN_CNT)
              score2 <= score2 + 2'd1;
          end
        end

        ST_ROUND_END: begin
          if (hold_cnt == HOLD_LAST) begin
            if (score1 == WIN_CNT || score2 == WIN_CNT) begin
              state     <= ST_MATCH_OVER;
              matchOver <= 1'b1;
              p1Match   <= (score1 == WIN_CNT);
              p2Match   <= (score1 != WIN_CNT);
            end else begin
              state      <= ST_ROUND_RESET;
              gameResetN <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        ST_MATCH_OVER: begin
          if (startMatch) begin
            state      <= ST_ROUND_RESET;
            gameResetN <= 1'b0;
            score1     <= 2'd0;
            score2     <= 2'd0;
            roundNum   <= 3'd0;
            matchOver  <= 1'b0;
            p1Match    <= 1'b0;
            p2Match    <= 1'b0;
          end
        end

        default: begin
          state      <= ST_IDLE;
          gameResetN <= 1'b0;
          fightEn    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_match_referee.sv
`default_nettype none
// ============================================================================
// tb_match_referee
// Directed, self-checking bench for match_referee with default parameters.
// Revision: 1.0
// ============================================================================
module tb_match_referee;
  import fight_pkg::*;

  logic       clk = 1'b0;
  logic       resetGame, startMatch, firstWin, secondWin, actionEnableIn;
  logic [1:0] health1, health2;
  logic       actionEnableOut, gameResetN, fightEn, matchOver, p1Match, p2Match;
  logic [1:0] score1, score2;
  logic [2:0] roundNum, refState;

  int total = 0;
  int bad   = 0;

  match_referee #(.WINS_TO_MATCH(2), .HOLD_CYCLES(4), .ROUND_TIMEOUT(64)) dut (
    .clk(clk), .resetGame(resetGame), .startMatch(startMatch),
    .firstWin(firstWin), .secondWin(secondWin),
    .health1(health1), .health2(health2),
    .actionEnableIn(actionEnableIn), .actionEnableOut(actionEnableOut),
    .gameResetN(gameResetN), .fightEn(fightEn),
    .score1(score1), .score2(score2), .roundNum(roundNum),
    .matchOver(matchOver), .p1Match(p1Match), .p2Match(p2Match),
    .refState(refState)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; outputs are then sampled 1 time unit later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    // get some activity going, then reset for two edges mid-FIGHT
    resetGame = 1'b1; startMatch = 1'b1; tick(1);
    startMatch = 1'b0; tick(3);
    resetGame = 1'b0; tick(2);
    total++;
    if (refState !== 3'b000 || gameResetN !== 1'b0 || score1 !== 2'd0 ||
        score2 !== 2'd0 || roundNum !== 3'd0 || matchOver !== 1'b0 ||
        fightEn !== 1'b0 || p1Match !== 1'b0 || p2Match !== 1'b0) begin
      bad++;
      $display("FAIL reset: st=%b grn=%b s1=%0d s2=%0d rn=%0d mo=%b fe=%b, want st=000 grn=0 all zero",
               refState, gameResetN, score1, score2, roundNum, matchOver, fightEn);
    end
    resetGame = 1'b1; tick(1);
    total++;
    if (refState !== 3'b000 || gameResetN !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: st=%b grn=%b want 000/0", refState, gameResetN);
    end
  endtask

  task automatic test_round_win;
    startMatch = 1'b1; tick(1);
    startMatch = 1'b0;
    total++;
    if (refState !== 3'b001 || gameResetN !== 1'b0) begin
      bad++;
      $display("FAIL round_reset_1: st=%b grn=%b want 001/0", refState, gameResetN);
    end
    tick(1);  // FIGHT cycle 1
    total++;
    if (refState !== 3'b010 || fightEn !== 1'b1 || gameResetN !== 1'b1 ||
        roundNum !== 3'd1 || actionEnableOut !== 1'b1) begin
      bad++;
      $display("FAIL fight_entry: st=%b fe=%b grn=%b rn=%0d aeo=%b want 010/1/1/1/1",
               refState, fightEn, gameResetN, roundNum, actionEnableOut);
    end
    tick(9);  // FIGHT cycle 10
    firstWin = 1'b1; tick(1);
    firstWin = 1'b0;
    total++;
    if (refState !== 3'b011 || score1 !== 2'd1 || score2 !== 2'd0 ||
        fightEn !== 1'b0 || gameResetN !== 1'b1) begin
      bad++;
      $display("FAIL round_end_score: st=%b s1=%0d s2=%0d fe=%b grn=%b want 011/1/0/0/1",
               refState, score1, score2, fightEn, gameResetN);
    end
    tick(3);  // ROUND_END cycle 4
    total++;
    if (refState !== 3'b011 || gameResetN !== 1'b1) begin
      bad++;
      $display("FAIL hold_len: st=%b grn=%b want 011/1", refState, gameResetN);
    end
    tick(1);
    total++;
    if (refState !== 3'b001 || gameResetN !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulse: st=%b grn=%b want 001/0", refState, gameResetN);
    end
    tick(1);
    total++;
    if (refState !== 3'b010 || gameResetN !== 1'b1 || roundNum !== 3'd2) begin
      bad++;
      $display("FAIL round2: st=%b grn=%b rn=%0d want 010/1/2", refState, gameResetN, roundNum);
    end
  endtask

  task automatic test_match_win;
    // in round 2 FIGHT cycle 1
    firstWin = 1'b1; startMatch = 1'b1; tick(1);  // startMatch ignored here
    firstWin = 1'b0; startMatch = 1'b0;
    total++;
    if (score1 !== 2'd2 || refState !== 3'b011 || roundNum !== 3'd2) begin
      bad++;
      $display("FAIL second_win: s1=%0d st=%b rn=%0d want 2/011/2", score1, refState, roundNum);
    end
    tick(4);
    total++;
    if (refState !== 3'b100 || matchOver !== 1'b1 || p1Match !== 1'b1 ||
        p2Match !== 1'b0 || score1 !== 2'd2 || score2 !== 2'd0 ||
        gameResetN !== 1'b1 || fightEn !== 1'b0) begin
      bad++;
      $display("FAIL match_over: st=%b mo=%b p1=%b p2=%b s1=%0d s2=%0d grn=%b fe=%b want 100/1/1/0/2/0/1/0",
               refState, matchOver, p1Match, p2Match, score1, score2, gameResetN, fightEn);
    end
    firstWin = 1'b1; tick(2);  // win flags ignored outside FIGHT
    firstWin = 1'b0;
    total++;
    if (refState !== 3'b100 || score1 !== 2'd2) begin
      bad++;
      $display("FAIL match_hold: st=%b s1=%0d want 100/2", refState, score1);
    end
    startMatch = 1'b1; tick(1);
    startMatch = 1'b0;
    total++;
    if (refState !== 3'b001 || score1 !== 2'd0 || score2 !== 2'd0 ||
        matchOver !== 1'b0 || p1Match !== 1'b0 || gameResetN !== 1'b0) begin
      bad++;
      $display("FAIL restart: st=%b s1=%0d s2=%0d mo=%b p1=%b grn=%b want 001/0/0/0/0/0",
               refState, score1, score2, matchOver, p1Match, gameResetN);
    end
    tick(1);
    total++;
    if (roundNum !== 3'd1 || refState !== 3'b010) begin
      bad++;
      $display("FAIL restart_round: rn=%0d st=%b want 1/010", roundNum, refState);
    end
  endtask

  task automatic test_draw;
    firstWin = 1'b1; secondWin = 1'b1; tick(1);
    firstWin = 1'b0; secondWin = 1'b0;
    total++;
    if (refState !== 3'b011 || score1 !== 2'd0 || score2 !== 2'd0) begin
      bad++;
      $display("FAIL draw: st=%b s1=%0d s2=%0d want 011/0/0", refState, score1, score2);
    end
    tick(5);
    total++;
    if (refState !== 3'b010 || roundNum !== 3'd2) begin
      bad++;
      $display("FAIL draw_replay: st=%b rn=%0d want 010/2", refState, roundNum);
    end
  endtask

  task automatic test_timeout;
    int aeo_bad;
    health1 = 2'd3; health2 = 2'd1;
    tick(63);  // FIGHT cycle 64, timer at terminal count
    total++;
    if (refState !== 3'b010 || score1 !== 2'd0) begin
      bad++;
      $display("FAIL pre_timeout: st=%b s1=%0d want 010/0", refState, score1);
    end
    tick(1);
    total++;
    if (refState !== 3'b011 || score1 !== 2'd1 || score2 !== 2'd0) begin
      bad++;
      $display("FAIL timeout_p1: st=%b s1=%0d s2=%0d want 011/1/0", refState, score1, score2);
    end
    aeo_bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (actionEnableOut !== 1'b0 || refState !== 3'b011) aeo_bad++;
      if (i < 3) tick(1);
    end
    total++;
    if (aeo_bad != 0) begin
      bad++;
      $display("FAIL aeo_round_end: bad_cycles=%0d want 0", aeo_bad);
    end
    tick(2);  // ROUND_RESET then FIGHT round 3
    total++;
    if (refState !== 3'b010 || roundNum !== 3'd3) begin
      bad++;
      $display("FAIL round3: st=%b rn=%0d want 010/3", refState, roundNum);
    end
    health1 = 2'd2; health2 = 2'd2;
    tick(64);
    total++;
    if (refState !== 3'b011 || score1 !== 2'd1 || score2 !== 2'd0) begin
      bad++;
      $display("FAIL timeout_draw: st=%b s1=%0d s2=%0d want 011/1/0", refState, score1, score2);
    end
    tick(5);  // round 4 FIGHT
    secondWin = 1'b1; tick(1);
    secondWin = 1'b0;
    total++;
    if (score1 !== 2'd1 || score2 !== 2'd1 || roundNum !== 3'd4) begin
      bad++;
      $display("FAIL p2_win: s1=%0d s2=%0d rn=%0d want 1/1/4", score1, score2, roundNum);
    end
    tick(5);  // round 5 FIGHT
    total++;
    if (refState !== 3'b010 || roundNum !== 3'd5) begin
      bad++;
      $display("FAIL round5: st=%b rn=%0d want 010/5", refState, roundNum);
    end
  endtask

  task automatic test_reset_with_start;
    resetGame = 1'b0; startMatch = 1'b1; tick(1);
    total++;
    if (refState !== 3'b000 || score1 !== 2'd0 || score2 !== 2'd0 ||
        roundNum !== 3'd0 || gameResetN !== 1'b0 || fightEn !== 1'b0) begin
      bad++;
      $display("FAIL reset_start: st=%b s1=%0d s2=%0d rn=%0d grn=%b fe=%b want 000/0/0/0/0/0",
               refState, score1, score2, roundNum, gameResetN, fightEn);
    end
    resetGame = 1'b1; startMatch = 1'b0; tick(2);
    total++;
    if (refState !== 3'b000 || actionEnableOut !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: st=%b aeo=%b want 000/0", refState, actionEnableOut);
    end
  endtask

  initial begin
    resetGame = 1'b0; startMatch = 1'b0; firstWin = 1'b0; secondWin = 1'b0;
    health1 = 2'd0; health2 = 2'd0; actionEnableIn = 1'b1;
    tick(2);
    test_reset;
    test_round_win;
    test_match_win;
    test_draw;
    test_timeout;
    test_reset_with_start;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
